pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Drives stall and flush enables for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Produces the EX-stage forwarding selects.
- Tracks multi-cycle data-memory waits with an FSM and a wait counter, and raises a sticky timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: stall/flush enables, EX forwarding selects,
// data-memory wait FSM with sticky timeout. Optional perf counters under PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int WAIT_MAX = 255,
  parameter int PCNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_we,
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_we,
  input  logic            ex_redirect,
  input  logic            dmem_req,
  input  logic            dmem_ack,
  output logic            pc_stall,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_stall,
  output logic            id_ex_flush,
  output logic            ex_mem_stall,
  output logic            mem_wb_flush,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [PCNT_W-1:0] perf_lu_stalls,
  output logic [PCNT_W-1:0] perf_flushes,
  output logic [PCNT_W-1:0] perf_mem_wait_cycles,
`endif
  output logic            mem_timeout
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             freeze, lu;
  logic             case_freeze, case_redirect, case_lu;

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (mem_reg_we && mem_rd != '0 && mem_rd == rs)
      return 2'b01;
    else if (wb_reg_we && wb_rd != '0 && wb_rd == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Priority cases are mutually exclusive and all suppressed while reset is held.
  always_comb begin
    freeze = dmem_req & ~dmem_ack;
    lu = ex_is_load & ex_reg_we & (ex_rd != '0) &
         ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    case_freeze   = ~rst & freeze;
    case_redirect = ~rst & ~freeze & ex_redirect;
    case_lu       = ~rst & ~freeze & ~ex_redirect & lu;

    pc_stall     = case_freeze | case_lu;
    if_id_stall  = case_freeze | case_lu;
    if_id_flush  = case_redirect;
    id_ex_stall  = case_freeze;
    id_ex_flush  = case_redirect | case_lu;
    ex_mem_stall = case_freeze;
    mem_wb_flush = case_freeze;

    fwd_a_sel = fwd_sel(ex_rs1);
    fwd_b_sel = fwd_sel(ex_rs2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (dmem_req && !dmem_ack) begin
            state    <= S_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (!dmem_req || dmem_ack) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
            // Saturated: flag the error but keep freezing; nothing here recovers.
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_stalls       <= '0;
      perf_flushes         <= '0;
      perf_mem_wait_cycles <= '0;
    end else begin
      if (case_lu)       perf_lu_stalls       <= perf_lu_stalls + PCNT_W'(1);
      if (case_redirect) perf_flushes         <= perf_flushes + PCNT_W'(1);
      if (case_freeze)   perf_mem_wait_cycles <= perf_mem_wait_cycles + PCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WAIT_MAX=4 so the timeout is reachable).
module tb_pipe_hazard_ctrl;

  localparam int RA_W = 5;

  // Stall/flush vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
  localparam logic [6:0] SF_NONE   = 7'b0000000;
  localparam logic [6:0] SF_FREEZE = 7'b1101011;
  localparam logic [6:0] SF_REDIR  = 7'b0010100;
  localparam logic [6:0] SF_LU     = 7'b1100100;

  logic            clk = 1'b0;
  logic            rst;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic            id_rs1_used, id_rs2_used, ex_reg_we, ex_is_load;
  logic            mem_reg_we, wb_reg_we, ex_redirect, dmem_req, dmem_ack;
  logic            pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic            ex_mem_stall, mem_wb_flush, mem_timeout;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]     perf_lu_stalls, perf_flushes, perf_mem_wait_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(RA_W), .WAIT_MAX(4), .PCNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_lu_stalls(perf_lu_stalls), .perf_flushes(perf_flushes),
    .perf_mem_wait_cycles(perf_mem_wait_cycles),
`endif
    .mem_timeout(mem_timeout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkSf(input string tag, input logic [6:0] exp);
    checkOutput(tag, {25'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                      id_ex_flush, ex_mem_stall, mem_wb_flush}, {25'd0, exp});
  endtask

  task automatic applyStimulus();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = '0; ex_reg_we = 0; ex_is_load = 0; ex_rs1 = '0; ex_rs2 = '0;
    mem_rd = '0; mem_reg_we = 0; wb_rd = '0; wb_reg_we = 0;
    ex_redirect = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // Inputs change on the falling edge; checks run 1ns later, clear of the rising edge.
  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    applyStimulus();
    rst = 1'b1;
    @(negedge clk);

    // Reset masks every stall/flush even with freeze, redirect and load-use all present
    dmem_req = 1; ex_redirect = 1; ex_is_load = 1; ex_reg_we = 1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs1_used = 1;
    #1 checkSf("reset_masks_outputs", SF_NONE);
    nextCycle();
    #1 checkOutput("reset_timeout_clear", {31'd0, mem_timeout}, 32'd0);

    // Load-use: one bubble
    rst = 0; applyStimulus();
    ex_is_load = 1; ex_reg_we = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
    #1 checkSf("load_use_stall", SF_LU);
    nextCycle();

    // Load now in MEM: forwarded from MEM, no stall
    applyStimulus();
    mem_rd = 5'd5; mem_reg_we = 1; ex_rs1 = 5'd5;
    #1 checkSf("load_in_mem_no_stall", SF_NONE);
    checkOutput("load_in_mem_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
    nextCycle();

    // x0 destination and unused operand never stall; x0 never forwards
    applyStimulus();
    ex_is_load = 1; ex_reg_we = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1;
    #1 checkSf("lu_x0_no_stall", SF_NONE);
    ex_rd = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd9; id_rs2_used = 0;
    #1 checkSf("lu_unused_rs2_no_stall", SF_NONE);
    id_rs2_used = 1;
    #1 checkSf("lu_rs2_used_stall", SF_LU);
    mem_rd = 5'd0; mem_reg_we = 1; ex_rs1 = 5'd0;
    #1 checkOutput("fwd_x0_none", {30'd0, fwd_a_sel}, 32'd0);
    nextCycle();

    // Forward priority: MEM over WB, then WB alone
    applyStimulus();
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_we = 1; wb_reg_we = 1; ex_rs2 = 5'd7; ex_rs1 = 5'd8;
    #1 checkOutput("fwd_b_mem_priority", {30'd0, fwd_b_sel}, 32'd1);
    checkOutput("fwd_a_no_match", {30'd0, fwd_a_sel}, 32'd0);
    mem_reg_we = 0;
    #1 checkOutput("fwd_b_wb", {30'd0, fwd_b_sel}, 32'd2);
    nextCycle();

    // Redirect beats load-use
    applyStimulus();
    ex_redirect = 1; ex_is_load = 1; ex_reg_we = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
    #1 checkSf("redirect_over_lu", SF_REDIR);
    nextCycle();

    // Zero-wait access: no freeze
    applyStimulus();
    dmem_req = 1; dmem_ack = 1;
    #1 checkSf("zero_wait_no_freeze", SF_NONE);
    nextCycle();

    // Three wait cycles with a pending redirect, which is taken on the ack cycle
    applyStimulus();
    dmem_req = 1; ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      #1 checkSf($sformatf("wait_freeze_%0d", i), SF_FREEZE);
      nextCycle();
    end
    dmem_ack = 1;
    #1 checkSf("ack_redirect_taken", SF_REDIR);
    nextCycle();
    applyStimulus();
    #1 checkSf("after_ack_idle", SF_NONE);
    checkOutput("after_ack_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // Abandoned access clears the wait counter, so the timeout needs 5 fresh wait edges
    dmem_req = 1;
    repeat (3) nextCycle();
    dmem_req = 0;
    nextCycle();
    dmem_req = 1;
    repeat (4) nextCycle();
    #1 checkOutput("timeout_not_yet", {31'd0, mem_timeout}, 32'd0);
    nextCycle();
    #1 checkOutput("timeout_set", {31'd0, mem_timeout}, 32'd1);
    checkSf("timeout_still_frozen", SF_FREEZE);
    dmem_req = 0;
    repeat (2) nextCycle();
    #1 checkOutput("timeout_sticky", {31'd0, mem_timeout}, 32'd1);

    // One reset edge clears the timeout and returns to RUN
    rst = 1; dmem_req = 1;
    #1 checkSf("reset_mid_wait_masks", SF_NONE);
    nextCycle();
    rst = 0; applyStimulus();
    #1 checkOutput("reset_clears_timeout", {31'd0, mem_timeout}, 32'd0);
    checkSf("post_reset_idle", SF_NONE);

    // Counter restarted from RUN: 4 wait edges must not time out
    dmem_req = 1;
    repeat (4) nextCycle();
    #1 checkOutput("post_reset_count_restart", {31'd0, mem_timeout}, 32'd0);
    nextCycle();
    #1 checkOutput("post_reset_timeout_again", {31'd0, mem_timeout}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
